// File: rtl/pll_drp_ctrl.sv
// Sequencer for the PLLA dynamic reconfiguration port: single-register read/write
// with optional PLL reset pulse and lock-stability wait before the response.
//
// state  | meaning
// IDLE   | ready for a request
// ADDR   | address load opcode on the port
// WDATA  | write opcode with data
// RD     | read opcode
// RWAIT  | waiting RD_LAT cycles for mdrdo
// RST    | pll_reset held high for RST_CYCLES
// LOCKW  | waiting for LOCK_STABLE consecutive lock cycles or timeout
// RESP   | one-cycle response pulse
module pll_drp_ctrl #(
    parameter int RD_LAT       = 2,
    parameter int RST_CYCLES   = 16,
    parameter int LOCK_STABLE  = 4,
    parameter int LOCK_TIMEOUT = 65535
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_write,
    input  logic [7:0] req_addr,
    input  logic [7:0] req_wdata,
    input  logic       req_relock,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       rsp_err,
    output logic       busy,
    output logic [1:0] mdopc,
    output logic       mdainc,
    output logic [7:0] mdwdi,
    input  logic [7:0] mdrdo,
    output logic       pll_reset,
    input  logic       pll_lock
);

    localparam logic [15:0] RD_LOAD   = 16'(RD_LAT - 1);
    localparam logic [15:0] RST_LOAD  = 16'(RST_CYCLES - 1);
    localparam logic [15:0] STABLE_TC = 16'(LOCK_STABLE);
    localparam logic [15:0] TMO_TC    = 16'(LOCK_TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_WDATA,
        S_RD,
        S_RWAIT,
        S_RST,
        S_LOCKW,
        S_RESP
    } state_t;

    state_t      state_q, state_d;
    logic        ready_q, ready_d;
    logic        write_q, write_d;
    logic        relock_q, relock_d;
    logic [7:0]  addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic [7:0]  rdata_q, rdata_d;
    logic        err_q, err_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] stable_q, stable_d;
    logic [15:0] tmo_q, tmo_d;
    logic        lock_meta_q, lock_s_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            ready_q     <= 1'b0;
            write_q     <= 1'b0;
            relock_q    <= 1'b0;
            addr_q      <= 8'h00;
            wdata_q     <= 8'h00;
            rdata_q     <= 8'h00;
            err_q       <= 1'b0;
            cnt_q       <= 16'h0000;
            stable_q    <= 16'h0000;
            tmo_q       <= 16'h0000;
            lock_meta_q <= 1'b0;
            lock_s_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            ready_q     <= ready_d;
            write_q     <= write_d;
            relock_q    <= relock_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
            stable_q    <= stable_d;
            tmo_q       <= tmo_d;
            lock_meta_q <= pll_lock;
            lock_s_q    <= lock_meta_q;
        end
    end

    always_comb begin
        state_d  = state_q;
        write_d  = write_q;
        relock_d = relock_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        cnt_d    = cnt_q;
        stable_d = stable_q;
        tmo_d    = tmo_q;

        case (state_q)
            S_IDLE: begin
                if (req_valid && ready_q) begin
                    write_d  = req_write;
                    relock_d = req_relock;
                    addr_d   = req_addr;
                    wdata_d  = req_wdata;
                    err_d    = 1'b0;
                    state_d  = S_ADDR;
                end
            end
            S_ADDR: begin
                state_d = write_q ? S_WDATA : S_RD;
            end
            S_WDATA: begin
                rdata_d = 8'h00;
                if (relock_q) begin
                    cnt_d    = RST_LOAD;
                    stable_d = 16'h0000;
                    tmo_d    = 16'h0000;
                    state_d  = S_RST;
                end else begin
                    state_d  = S_RESP;
                end
            end
            S_RD: begin
                cnt_d   = RD_LOAD;
                state_d = S_RWAIT;
            end
            S_RWAIT: begin
                if (cnt_q == 16'h0000) begin
                    rdata_d = mdrdo;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - 16'h0001;
                end
            end
            S_RST: begin
                if (cnt_q == 16'h0000) begin
                    state_d = S_LOCKW;
                end else begin
                    cnt_d = cnt_q - 16'h0001;
                end
            end
            S_LOCKW: begin
                stable_d = lock_s_q ? (stable_q + 16'h0001) : 16'h0000;
                tmo_d    = tmo_q + 16'h0001;
                // a stable lock reached on the same cycle as the timeout still counts as success
                if (stable_d == STABLE_TC) begin
                    err_d   = 1'b0;
                    state_d = S_RESP;
                end else if (tmo_d == TMO_TC) begin
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        ready_d = (state_d == S_IDLE);
    end

    always_comb begin
        mdopc = 2'b00;
        mdwdi = 8'h00;
        case (state_q)
            S_ADDR: begin
                mdopc = 2'b11;
                mdwdi = addr_q;
            end
            S_WDATA: begin
                mdopc = 2'b01;
                mdwdi = wdata_q;
            end
            S_RD: begin
                mdopc = 2'b10;
            end
            default: begin
                mdopc = 2'b00;
            end
        endcase
    end

    // outputs decode straight from state so an async reset clears them immediately
    assign req_ready = ready_q;
    assign busy      = (state_q != S_IDLE);
    assign rsp_valid = (state_q == S_RESP);
    assign rsp_err   = (state_q == S_RESP) && err_q;
    assign rsp_rdata = rdata_q;
    assign pll_reset = (state_q == S_RST);
    assign mdainc    = 1'b0;

endmodule

// File: tb/tb_pll_drp_ctrl.sv
// Directed bench for pll_drp_ctrl: write, read, relock, lock glitch, timeout,
// back-to-back requests and reset during the PLL reset pulse.
module tb_pll_drp_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic       req_write = 1'b0;
    logic [7:0] req_addr = 8'h00;
    logic [7:0] req_wdata = 8'h00;
    logic       req_relock = 1'b0;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       rsp_err;
    logic       busy;
    logic [1:0] mdopc;
    logic       mdainc;
    logic [7:0] mdwdi;
    logic [7:0] mdrdo = 8'h00;
    logic       pll_reset;
    logic       pll_lock = 1'b0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pll_drp_ctrl #(
        .RD_LAT      (2),
        .RST_CYCLES  (16),
        .LOCK_STABLE (4),
        .LOCK_TIMEOUT(100)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_relock(req_relock),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .busy      (busy),
        .mdopc     (mdopc),
        .mdainc    (mdainc),
        .mdwdi     (mdwdi),
        .mdrdo     (mdrdo),
        .pll_reset (pll_reset),
        .pll_lock  (pll_lock)
    );

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // drives one request for the accept edge, then scrambles the fields
    task automatic send(input logic w, input logic [7:0] a, input logic [7:0] d, input logic rl);
        req_valid  = 1'b1;
        req_write  = w;
        req_addr   = a;
        req_wdata  = d;
        req_relock = rl;
        tick();
        req_valid  = 1'b0;
        req_write  = ~w;
        req_addr   = 8'hFF;
        req_wdata  = 8'hEE;
        req_relock = 1'b0;
    endtask

    // called in the WDATA cycle; returns after pll_reset falls with its width in cycles
    task automatic measure_rst(input logic lk, output int n);
        tick();
        pll_lock = lk;
        n = 0;
        while (pll_reset === 1'b1 && n < 40) begin
            n++;
            tick();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int k;
        int seen;

        // reset values
        #1 reset = 1'b1;
        #2;
        chk("rst_ready", 32'(req_ready), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_mdopc", 32'(mdopc), 32'h0);
        chk("rst_mdwdi", 32'(mdwdi), 32'h0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_rdata", 32'(rsp_rdata), 32'h0);
        chk("rst_err", 32'(rsp_err), 32'h0);
        chk("rst_pll_reset", 32'(pll_reset), 32'h0);
        chk("rst_mdainc", 32'(mdainc), 32'h0);
        repeat (2) tick();
        reset = 1'b0;
        #1;
        chk("ready_before_edge", 32'(req_ready), 32'h0);
        tick();
        chk("ready_after_reset", 32'(req_ready), 32'h1);

        // write 0x32 to 0x12, no relock
        send(1'b1, 8'h12, 8'h32, 1'b0);
        chk("wr_c1_opc", 32'(mdopc), 32'h3);
        chk("wr_c1_wdi", 32'(mdwdi), 32'h12);
        chk("wr_c1_ready", 32'(req_ready), 32'h0);
        chk("wr_c1_busy", 32'(busy), 32'h1);
        tick();
        chk("wr_c2_opc", 32'(mdopc), 32'h1);
        chk("wr_c2_wdi", 32'(mdwdi), 32'h32);
        chk("wr_c2_prst", 32'(pll_reset), 32'h0);
        tick();
        chk("wr_c3_valid", 32'(rsp_valid), 32'h1);
        chk("wr_c3_err", 32'(rsp_err), 32'h0);
        chk("wr_c3_opc", 32'(mdopc), 32'h0);
        chk("wr_c3_prst", 32'(pll_reset), 32'h0);
        tick();
        chk("wr_c4_valid", 32'(rsp_valid), 32'h0);
        chk("wr_c4_ready", 32'(req_ready), 32'h1);
        chk("wr_c4_busy", 32'(busy), 32'h0);

        // read 0x05; model data valid only in cycle 4
        send(1'b0, 8'h05, 8'h00, 1'b1);
        chk("rd_c1_opc", 32'(mdopc), 32'h3);
        chk("rd_c1_wdi", 32'(mdwdi), 32'h05);
        tick();
        chk("rd_c2_opc", 32'(mdopc), 32'h2);
        chk("rd_c2_wdi", 32'(mdwdi), 32'h00);
        mdrdo = 8'h5A;
        tick();
        chk("rd_c3_opc", 32'(mdopc), 32'h0);
        chk("rd_c3_valid", 32'(rsp_valid), 32'h0);
        tick();
        mdrdo = 8'hA7;
        chk("rd_c4_valid", 32'(rsp_valid), 32'h0);
        tick();
        chk("rd_c5_valid", 32'(rsp_valid), 32'h1);
        chk("rd_c5_rdata", 32'(rsp_rdata), 32'hA7);
        chk("rd_c5_err", 32'(rsp_err), 32'h0);
        chk("rd_c5_prst", 32'(pll_reset), 32'h0);
        mdrdo = 8'h33;
        tick();
        chk("rd_c6_valid", 32'(rsp_valid), 32'h0);
        chk("rd_c6_hold", 32'(rsp_rdata), 32'hA7);
        chk("rd_c6_ready", 32'(req_ready), 32'h1);

        // write+relock, lock rises 40 cycles after pll_reset falls
        pll_lock = 1'b1;
        send(1'b1, 8'h40, 8'h9C, 1'b1);
        chk("rl_c1_wdi", 32'(mdwdi), 32'h40);
        tick();
        chk("rl_c2_opc", 32'(mdopc), 32'h1);
        chk("rl_c2_wdi", 32'(mdwdi), 32'h9C);
        measure_rst(1'b0, n);
        chk("rl_rst_width", n, 16);
        chk("rl_lockw_opc", 32'(mdopc), 32'h0);
        chk("rl_lockw_busy", 32'(busy), 32'h1);
        seen = 0;
        repeat (40) begin
            tick();
            if (rsp_valid === 1'b1) seen++;
        end
        chk("rl_no_early_rsp", seen, 0);
        pll_lock = 1'b1;
        k = 0;
        while (rsp_valid !== 1'b1 && k < 20) begin
            tick();
            k++;
        end
        chk("rl_lock_latency", k, 6);
        chk("rl_err", 32'(rsp_err), 32'h0);
        chk("rl_rdata_zero", 32'(rsp_rdata), 32'h0);
        tick();
        chk("rl_ready_after", 32'(req_ready), 32'h1);

        // lock glitch: high 3, low 1, high
        send(1'b1, 8'h41, 8'h5A, 1'b1);
        tick();
        measure_rst(1'b0, n);
        chk("gl_rst_width", n, 16);
        pll_lock = 1'b1;
        k = 0;
        while (rsp_valid !== 1'b1 && k < 30) begin
            tick();
            k++;
            if (k == 3) pll_lock = 1'b0;
            if (k == 4) pll_lock = 1'b1;
        end
        chk("gl_latency", k, 10);
        chk("gl_err", 32'(rsp_err), 32'h0);

        // lock stuck low -> timeout after 100 LOCKW cycles
        tick();
        pll_lock = 1'b0;
        send(1'b1, 8'h42, 8'h0F, 1'b1);
        tick();
        measure_rst(1'b0, n);
        k = 0;
        while (rsp_valid !== 1'b1 && k < 200) begin
            tick();
            k++;
        end
        chk("to_latency", k, 100);
        chk("to_valid", 32'(rsp_valid), 32'h1);
        chk("to_err", 32'(rsp_err), 32'h1);
        tick();
        chk("to_valid_drop", 32'(rsp_valid), 32'h0);
        chk("to_err_drop", 32'(rsp_err), 32'h0);
        chk("to_ready", 32'(req_ready), 32'h1);

        // req_valid held across two writes; fields change after first accept
        req_valid  = 1'b1;
        req_write  = 1'b1;
        req_addr   = 8'h21;
        req_wdata  = 8'h55;
        req_relock = 1'b0;
        tick();
        req_addr  = 8'h22;
        req_wdata = 8'h66;
        chk("b2b_c1_wdi", 32'(mdwdi), 32'h21);
        chk("b2b_c1_ready", 32'(req_ready), 32'h0);
        tick();
        chk("b2b_c2_wdi", 32'(mdwdi), 32'h55);
        tick();
        chk("b2b_c3_valid", 32'(rsp_valid), 32'h1);
        chk("b2b_c3_ready", 32'(req_ready), 32'h0);
        tick();
        chk("b2b_c4_ready", 32'(req_ready), 32'h1);
        chk("b2b_c4_opc", 32'(mdopc), 32'h0);
        tick();
        req_valid = 1'b0;
        chk("b2b_c5_opc", 32'(mdopc), 32'h3);
        chk("b2b_c5_wdi", 32'(mdwdi), 32'h22);
        tick();
        chk("b2b_c6_wdi", 32'(mdwdi), 32'h66);
        tick();
        chk("b2b_c7_valid", 32'(rsp_valid), 32'h1);
        tick();

        // reset asserted during the PLL reset pulse
        send(1'b1, 8'h43, 8'h01, 1'b1);
        tick();
        repeat (6) tick();
        chk("mr_prst_before", 32'(pll_reset), 32'h1);
        reset = 1'b1;
        #1;
        chk("mr_prst", 32'(pll_reset), 32'h0);
        chk("mr_busy", 32'(busy), 32'h0);
        chk("mr_opc", 32'(mdopc), 32'h0);
        chk("mr_ready", 32'(req_ready), 32'h0);
        seen = 0;
        repeat (3) begin
            tick();
            if (rsp_valid !== 1'b0) seen++;
        end
        chk("mr_no_rsp", seen, 0);
        reset = 1'b0;
        tick();
        chk("mr_ready_after", 32'(req_ready), 32'h1);
        mdrdo = 8'h3C;
        send(1'b0, 8'h07, 8'h00, 1'b0);
        chk("mr_rd_c1_wdi", 32'(mdwdi), 32'h07);
        tick();
        chk("mr_rd_c2_opc", 32'(mdopc), 32'h2);
        repeat (3) tick();
        chk("mr_rd_c5_valid", 32'(rsp_valid), 32'h1);
        chk("mr_rd_c5_rdata", 32'(rsp_rdata), 32'h3C);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pll_drp_ctrl.md
# pll_drp_ctrl

Sequencer that drives the dynamic reconfiguration port (MDOPC/MDAINC/MDWDI/MDRDO) of the 24 MHz-family PLLA wrapper, upstream of it. It accepts single-register read/write requests from the command layer over a valid/ready handshake, issues the port cycle sequence and optionally pulses the PLL reset and waits for a stable lock before responding. The PLL's `mdclk` is tied to this block's `clk` at the top level.

## Interface
Parameters:
- `RD_LAT`, 2: cycles from the read-opcode cycle to valid `mdrdo` (1..7).
- `RST_CYCLES`, 16: width of the `pll_reset` pulse in `clk` cycles (>=1).
- `LOCK_STABLE`, 4: consecutive synchronized-lock-high cycles required (>=1).
- `LOCK_TIMEOUT`, 65535: maximum cycles in lock wait before error (16-bit counter).

Ports:
- `clk` in 1: system clock; also drives PLL `mdclk`.
- `reset` in 1: asynchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: high only in IDLE.
- `req_write` in 1: 1 = write, 0 = read.
- `req_addr` in 8: PLL register address.
- `req_wdata` in 8: write data.
- `req_relock` in 1: after a write, pulse PLL reset and wait for lock; ignored for reads.
- `rsp_valid` out 1: one-cycle response pulse.
- `rsp_rdata` out 8: read data (holds last captured value; 0 after writes).
- `rsp_err` out 1: lock timeout; valid with `rsp_valid`.
- `busy` out 1: not IDLE.
- `mdopc` out 2: 00 idle, 11 address load, 01 write, 10 read.
- `mdainc` out 1: constant 0 (no auto-increment).
- `mdwdi` out 8: address or data for the current opcode.
- `mdrdo` in 8: PLL read data.
- `pll_reset` out 1: to PLL `reset`.
- `pll_lock` in 1: PLL `lock`, asynchronous to `clk`.

## Operation
- Reset values: `req_ready`=0 during reset then 1 the first cycle after; `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0, `busy`=0, `mdopc`=00, `mdainc`=0, `mdwdi`=0, `pll_reset`=0; all counters and lock synchronizer cleared.
- `pll_lock` passes through a 2-flop synchronizer (`lock_s`) before use.
- Request fields are registered on accept (`req_valid && req_ready`); later input changes ignored.
- States: IDLE -> ADDR -> (write) WDATA / (read) RD -> RWAIT -> RESP; WDATA -> RESP, or WDATA -> RST -> LOCKW -> RESP when `req_relock`=1.
- ADDR: `mdopc`=11, `mdwdi`=addr, 1 cycle.
- WDATA: `mdopc`=01, `mdwdi`=wdata, 1 cycle.
- RD: `mdopc`=10, `mdwdi`=0, 1 cycle. RWAIT: `mdopc`=00 for RD_LAT cycles; `mdrdo` captured into `rsp_rdata` at the end of the last RWAIT cycle.
- RST: `pll_reset`=1 for exactly RST_CYCLES cycles, `mdopc`=00.
- LOCKW: stable counter increments while `lock_s`=1, clears to 0 when `lock_s`=0; reaching LOCK_STABLE -> RESP, err=0. Timeout counter starts at 0 on entry, increments every LOCKW cycle; reaching LOCK_TIMEOUT first -> RESP, err=1. Stable wins if both hit the same cycle.
- RESP: `rsp_valid`=1 one cycle, `rsp_err` set per above (0 for non-relock ops), then IDLE. No backpressure on response.
- `mdopc` returns to 00 in every state other than ADDR/WDATA/RD.
- `reset` asserted mid-sequence: immediate return to reset values, no response emitted; `pll_reset` drops with it (top level keeps PLL reset ORed with system reset).

## Timing
- Accept at cycle 0 (edge where handshake seen). ADDR = cycle 1.
- Write, no relock: WDATA cycle 2, `rsp_valid` cycle 3.
- Read: RD cycle 2, RWAIT cycles 3..2+RD_LAT, `rsp_valid` cycle 3+RD_LAT (cycle 5 default).
- Write+relock: RST cycles 3..2+RST_CYCLES, LOCKW from cycle 3+RST_CYCLES; minimum `rsp_valid` = LOCKW entry + LOCK_STABLE.
- Back-to-back: `req_ready` rises the cycle after RESP; next ADDR at earliest 2 cycles after RESP.

## Test plan
- Write addr 0x12 data 0x32, relock=0 -> `mdopc` 11/0x12 cycle 1, 01/0x32 cycle 2, `rsp_valid` cycle 3, err=0, `pll_reset` never high.
- Read addr 0x05 with model returning 0xA7 two cycles after opcode 10 -> `rsp_rdata`=0xA7 with `rsp_valid` at cycle 5.
- Write+relock, model lock drops during reset and rises 40 cycles after -> `pll_reset` high exactly 16 cycles, response err=0 no earlier than lock rise + 2 sync + 4 stable.
- Write+relock, lock glitches (high 3, low 1, high) -> stable counter restarts; response only after 4 consecutive high; LOCK_TIMEOUT=100 with lock stuck low -> `rsp_valid` with err=1 exactly 100 cycles into LOCKW.
- `req_valid` held across two requests -> second accepted only after first response; fields changed after accept do not affect `mdwdi`.
- Assert `reset` during RST -> `pll_reset`, `busy`, `mdopc` to 0 asynchronously, no `rsp_valid`, next request completes normally.
